// File: rtl/qed_pkg.sv
// Shared definitions for the SQED duplicate scheduler.
// Contents:
//   STATE_W        - width of the FSM state field
//   DEF_MAX_INST   - default originals recorded before a forced switch to DUP
//   DEF_PIPE_DEPTH - default drain length in cycles
//   state_t        - scheduler FSM states
package qed_pkg;

    localparam int STATE_W        = 3;
    localparam int DEF_MAX_INST   = 8;
    localparam int DEF_PIPE_DEPTH = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        ORIG  = 3'd1,
        DUP   = 3'd2,
        DRAIN = 3'd3,
        CHECK = 3'd4
    } state_t;

endpackage

// File: rtl/qed_drain_timer.sv
// Pipeline drain timer: loadable down-counter with a done indication.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous reset, active-low
//   clr   - synchronous clear to zero (abort)
//   load  - load PIPE_DEPTH-1 (start of drain)
//   en    - count down while high (drain in progress)
//   done  - high on the final cycle of the drain window
module qed_drain_timer
    import qed_pkg::*;
#(
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int TW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(PIPE_DEPTH - 1);

    logic [TW-1:0] cnt;

    // Counting down from PIPE_DEPTH-1 to 0 gives the same PIPE_DEPTH-cycle
    // window as an up-count 0..PIPE_DEPTH-1, with a cheaper terminal test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = en & (cnt == '0);

endmodule

// File: rtl/qed_dup_scheduler.sv
// SQED sequencing controller: runs originals, replays duplicates from the
// QED i-cache, drains the pipeline and flags the consistency-check point.
// Ports:
//   clk, rst                 - clock (rising) / async active-low reset
//   qed_en                   - QED mode enable (level)
//   dup_req                  - request to begin duplicate replay
//   stall_IF                 - fetch stalled; nothing counted this cycle
//   ifu_vld, inst_is_qed     - valid, duplicable original instruction
//   qic_vld                  - QED i-cache has a duplicate to issue
//   ena, exec_dup            - instruction-mux enable / duplicate select
//   hold_fetch               - request IFU stall during drain/check
//   orig_cnt, dup_cnt        - originals recorded / duplicates issued
//   qed_ready                - counts equal and pipeline drained
//   state                    - current FSM state (debug)
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int MAX_INST   = DEF_MAX_INST,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int CNT_W      = $clog2(MAX_INST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               qed_en,
    input  logic               dup_req,
    input  logic               stall_IF,
    input  logic               ifu_vld,
    input  logic               inst_is_qed,
    input  logic               qic_vld,
    output logic               ena,
    output logic               exec_dup,
    output logic               hold_fetch,
    output logic [CNT_W-1:0]   orig_cnt,
    output logic [CNT_W-1:0]   dup_cnt,
    output logic               qed_ready,
    output logic [STATE_W-1:0] state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] orig_q, orig_d, dup_q, dup_d;
    logic [CNT_W-1:0] orig_inc, dup_inc;
    logic             accept_o, accept_d, dup_room;
    logic             timer_load, timer_clr, timer_done;

    assign accept_o = ifu_vld & inst_is_qed & ~stall_IF;
    assign accept_d = qic_vld & ~stall_IF;
    // A duplicate beyond the recorded originals is never counted.
    assign dup_room = dup_q < orig_q;
    assign orig_inc = orig_q + CNT_W'(accept_o);
    assign dup_inc  = dup_q + CNT_W'(accept_d & dup_room);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            orig_q  <= '0;
            dup_q   <= '0;
        end else begin
            state_q <= state_d;
            orig_q  <= orig_d;
            dup_q   <= dup_d;
        end
    end

    // Transition decisions use the post-increment counts so the count is
    // final in the same cycle the state changes.
    always_comb begin
        state_d    = state_q;
        orig_d     = orig_q;
        dup_d      = dup_q;
        timer_load = 1'b0;
        timer_clr  = 1'b0;
        if (state_q != IDLE && !qed_en) begin
            state_d   = IDLE;
            orig_d    = '0;
            dup_d     = '0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (qed_en) state_d = ORIG;
                end
                ORIG: begin
                    orig_d = orig_inc;
                    if ((dup_req && (orig_q != '0 || accept_o)) ||
                        orig_inc == CNT_W'(MAX_INST)) begin
                        state_d = DUP;
                    end
                end
                DUP: begin
                    dup_d = dup_inc;
                    if (dup_inc == orig_q) begin
                        state_d    = DRAIN;
                        timer_load = 1'b1;
                    end
                end
                DRAIN: begin
                    if (timer_done) state_d = CHECK;
                end
                CHECK: begin
                end
                default: begin
                    state_d   = IDLE;
                    orig_d    = '0;
                    dup_d     = '0;
                    timer_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ena        = 1'b0;
        exec_dup   = 1'b0;
        hold_fetch = 1'b0;
        qed_ready  = 1'b0;
        case (state_q)
            ORIG:  ena = 1'b1;
            DUP: begin
                ena      = 1'b1;
                exec_dup = 1'b1;
            end
            DRAIN: begin
                ena        = 1'b1;
                exec_dup   = 1'b1;
                hold_fetch = 1'b1;
            end
            CHECK: begin
                ena        = 1'b1;
                hold_fetch = 1'b1;
                qed_ready  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    qed_drain_timer #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_drain_timer (
        .clk  (clk),
        .rst_n(rst),
        .clr  (timer_clr),
        .load (timer_load),
        .en   (state_q == DRAIN),
        .done (timer_done)
    );

    assign orig_cnt = orig_q;
    assign dup_cnt  = dup_q;
    assign state    = state_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Self-checking bench for qed_dup_scheduler (MAX_INST=8, PIPE_DEPTH=5).
// Expected state/counts for each cycle are queued as stimulus is driven and
// compared once the clock edge has produced the DUT response.
module tb_qed_dup_scheduler;

    localparam int MI = 8;
    localparam int PD = 5;
    localparam int CW = $clog2(MI + 1);

    localparam int S_IDLE  = 0;
    localparam int S_ORIG  = 1;
    localparam int S_DUP   = 2;
    localparam int S_DRAIN = 3;
    localparam int S_CHECK = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          qed_en = 1'b0, dup_req = 1'b0, stall_IF = 1'b0;
    logic          ifu_vld = 1'b0, inst_is_qed = 1'b0, qic_vld = 1'b0;
    logic          ena, exec_dup, hold_fetch, qed_ready;
    logic [CW-1:0] orig_cnt, dup_cnt;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    st;
        int    oc;
        int    dc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    qed_dup_scheduler #(
        .MAX_INST  (MI),
        .PIPE_DEPTH(PD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .qed_en     (qed_en),
        .dup_req    (dup_req),
        .stall_IF   (stall_IF),
        .ifu_vld    (ifu_vld),
        .inst_is_qed(inst_is_qed),
        .qic_vld    (qic_vld),
        .ena        (ena),
        .exec_dup   (exec_dup),
        .hold_fetch (hold_fetch),
        .orig_cnt   (orig_cnt),
        .dup_cnt    (dup_cnt),
        .qed_ready  (qed_ready),
        .state      (state)
    );

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic drive(input logic en, input logic dreq, input logic stl,
                         input logic iv, input logic iq, input logic qv);
        qed_en      = en;
        dup_req     = dreq;
        stall_IF    = stl;
        ifu_vld     = iv;
        inst_is_qed = iq;
        qic_vld     = qv;
    endtask

    // Output decode expected for each state.
    task automatic chk_outputs(input string tag, input int st);
        int w_ena, w_dup, w_hold, w_rdy;
        w_ena  = (st != S_IDLE) ? 1 : 0;
        w_dup  = (st == S_DUP || st == S_DRAIN) ? 1 : 0;
        w_hold = (st == S_DRAIN || st == S_CHECK) ? 1 : 0;
        w_rdy  = (st == S_CHECK) ? 1 : 0;
        if (st != S_DRAIN) chk({tag, ".ena"}, int'(ena), w_ena);
        chk({tag, ".exec_dup"},   int'(exec_dup), w_dup);
        chk({tag, ".hold_fetch"}, int'(hold_fetch), w_hold);
        chk({tag, ".qed_ready"},  int'(qed_ready), w_rdy);
    endtask

    // Queue the expectation for the cycle after the currently driven inputs,
    // clock once, then compare everything queued.
    task automatic step(input string tag, input int st, input int oc, input int dc);
        exp_t e;
        e.tag = tag; e.st = st; e.oc = oc; e.dc = dc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".state"}, int'(state), e.st);
            chk({e.tag, ".orig"},  int'(orig_cnt), e.oc);
            chk({e.tag, ".dup"},   int'(dup_cnt), e.dc);
            chk({e.tag, ".dup_le_orig"}, (dup_cnt <= orig_cnt) ? 1 : 0, 1);
            chk_outputs(e.tag, e.st);
        end
    endtask

    task automatic chk_idle_now(input string tag);
        chk({tag, ".state"}, int'(state), S_IDLE);
        chk({tag, ".orig"},  int'(orig_cnt), 0);
        chk({tag, ".dup"},   int'(dup_cnt), 0);
        chk_outputs(tag, S_IDLE);
    endtask

    initial begin
        // 1. Reset with qed_en high: everything stays zero.
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_now("rst_hold");
        rst = 1'b1;
        step("rst_rel", S_ORIG, 0, 0);

        // 2. Basic flow: 3 originals, dup_req, 3 duplicates, drain, check.
        drive(1, 0, 0, 1, 1, 0);
        step("b_o1", S_ORIG, 1, 0);
        step("b_o2", S_ORIG, 2, 0);
        step("b_o3", S_ORIG, 3, 0);
        drive(1, 1, 0, 0, 0, 0);
        step("b_req", S_DUP, 3, 0);
        drive(1, 0, 0, 0, 0, 1);
        step("b_d1", S_DUP, 3, 1);
        step("b_d2", S_DUP, 3, 2);
        step("b_d3", S_DRAIN, 3, 3);
        for (int i = 1; i < PD; i++) step($sformatf("b_drain%0d", i), S_DRAIN, 3, 3);
        step("b_ready", S_CHECK, 3, 3);
        drive(1, 0, 0, 1, 1, 1);
        step("b_hold1", S_CHECK, 3, 3);
        step("b_hold2", S_CHECK, 3, 3);
        drive(0, 0, 0, 0, 0, 0);
        step("b_off", S_IDLE, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step("b_on", S_ORIG, 0, 0);

        // 3. Forced switch at MAX_INST.
        drive(1, 0, 0, 1, 1, 0);
        for (int i = 1; i < MI; i++) step($sformatf("f_o%0d", i), S_ORIG, i, 0);
        step("f_max", S_DUP, MI, 0);
        step("f_sat", S_DUP, MI, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("f_off", S_IDLE, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step("f_on", S_ORIG, 0, 0);

        // 4. Stalls and filtering; then 6a: abort in DRAIN.
        drive(1, 0, 1, 1, 1, 0);
        step("s_stall", S_ORIG, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        step("s_nonqed", S_ORIG, 0, 0);
        drive(1, 0, 0, 1, 1, 0);
        step("s_o1", S_ORIG, 1, 0);
        step("s_o2", S_ORIG, 2, 0);
        drive(1, 1, 0, 0, 0, 0);
        step("s_req", S_DUP, 2, 0);
        drive(1, 0, 0, 0, 0, 1);
        step("s_d1", S_DUP, 2, 1);
        drive(1, 0, 1, 0, 0, 1);
        step("s_dstall1", S_DUP, 2, 1);
        step("s_dstall2", S_DUP, 2, 1);
        drive(1, 0, 0, 0, 0, 1);
        step("s_d2", S_DRAIN, 2, 2);
        step("s_drain", S_DRAIN, 2, 2);
        drive(0, 0, 0, 0, 0, 1);
        step("a_off", S_IDLE, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step("a_on", S_ORIG, 0, 0);

        // 5. Early dup_req ignored at zero count; coincident with first accept.
        drive(1, 1, 0, 0, 0, 0);
        step("e_ign1", S_ORIG, 0, 0);
        step("e_ign2", S_ORIG, 0, 0);
        drive(1, 1, 1, 1, 1, 0);
        step("e_stall", S_ORIG, 0, 0);
        drive(1, 1, 0, 1, 1, 0);
        step("e_coinc", S_DUP, 1, 0);
        drive(1, 1, 0, 1, 1, 1);
        step("e_d1", S_DRAIN, 1, 1);
        step("e_drain", S_DRAIN, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        step("e_off", S_IDLE, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step("e_on", S_ORIG, 0, 0);

        // 6b. Asynchronous reset mid-DUP.
        drive(1, 0, 0, 1, 1, 0);
        step("r_o1", S_ORIG, 1, 0);
        step("r_o2", S_ORIG, 2, 0);
        drive(1, 1, 0, 0, 0, 0);
        step("r_req", S_DUP, 2, 0);
        drive(1, 0, 0, 0, 0, 1);
        step("r_d1", S_DUP, 2, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle_now("r_async");
        @(posedge clk);
        #1;
        chk_idle_now("r_held");
        drive(1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("r_rel", S_ORIG, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
